// File: rtl/register_file_2r1w.sv
// register_file_2r1w
//   Register file with one write port and two independent read ports.
//   Reads are registered (one-cycle latency) with a one-cycle valid pulse,
//   and a same-edge write to the read address is forwarded (write-first).
//   Out-of-range accesses read as zero, never modify storage, and set a
//   sticky error flag that only reset clears.
//
// Parameters
//   WIDTH   data bits per entry
//   DEPTH   number of entries (need not be a power of two)
//   AW      address bits, 2**AW >= DEPTH
//   ZERO_R0 1: entry 0 always reads as zero and ignores writes
//
// Ports
//   clk                        rising-edge clock
//   reset                      synchronous active-high reset
//   write_en/addr/port_1       write request, address, data
//   read_en_x/read_addr_x      read request and address, x = 1,2
//   read_port_x/read_valid_x   registered read data and valid pulse
//   addr_err                   sticky out-of-range access flag
module register_file_2r1w #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_port_1,
  input  logic             read_en_1,
  input  logic             read_en_2,
  input  logic [AW-1:0]    read_addr_1,
  input  logic [AW-1:0]    read_addr_2,
  output logic [WIDTH-1:0] read_port_1,
  output logic [WIDTH-1:0] read_port_2,
  output logic             read_valid_1,
  output logic             read_valid_2,
  output logic             addr_err
);

  // DEPTH can equal 2**AW, so the range compare needs one extra bit.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // Storage is flop-based: reset must clear every entry in one edge.
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             addr_err_reg;

  logic wr_in_range;
  logic wr_is_r0;
  logic wr_commit;
  logic wr_err;

  assign wr_in_range = ({1'b0, write_addr} < DEPTH_W);
  assign wr_is_r0    = (ZERO_R0 != 0) && (write_addr == '0);
  // A write to the hard-wired zero entry is silently dropped, not an error.
  assign wr_commit   = write_en && wr_in_range && !wr_is_r0;
  assign wr_err      = write_en && !wr_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_commit) begin
      mem_reg[write_addr] <= write_port_1;
    end
  end

  // Two identical read ports; each keeps its own data/valid registers.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic             en;
    logic [AW-1:0]    addr;
    logic             in_range;
    logic             err;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    assign en       = (gi == 0) ? read_en_1   : read_en_2;
    assign addr     = (gi == 0) ? read_addr_1 : read_addr_2;
    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign err      = en && !in_range;

    always_ff @(posedge clk) begin
      if (reset) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= en;
        // With en low the data register simply holds its last value.
        if (en) begin
          if (!in_range || ((ZERO_R0 != 0) && (addr == '0))) begin
            data_reg <= '0;
          end else if (wr_commit && (addr == write_addr)) begin
            // Write-first forwarding: return the data landing this edge.
            data_reg <= write_port_1;
          end else begin
            data_reg <= mem_reg[addr];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err_reg <= 1'b0;
    end else if (wr_err || g_rd[0].err || g_rd[1].err) begin
      addr_err_reg <= 1'b1;
    end
  end

  assign read_port_1  = g_rd[0].data_reg;
  assign read_port_2  = g_rd[1].data_reg;
  assign read_valid_1 = g_rd[0].valid_reg;
  assign read_valid_2 = g_rd[1].valid_reg;
  assign addr_err     = addr_err_reg;

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w
//   Drives two instances from one shared stimulus stream:
//     A: DEPTH=6, ZERO_R0=0   (out-of-range addresses 6,7)
//     B: DEPTH=8, ZERO_R0=1   (entry 0 hard-wired to zero)
//   A reference model (array storage, write applied before the reads of
//   the same edge) predicts every output; directed steps add explicit
//   constant checks, followed by a randomized phase.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic        read_en_1, read_en_2;
  logic [2:0]  read_addr_1, read_addr_2;

  logic [15:0] rp1_a, rp2_a, rp1_b, rp2_b;
  logic        rv1_a, rv2_a, rv1_b, rv2_b;
  logic        err_a, err_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  register_file_2r1w #(.WIDTH(16), .DEPTH(6), .AW(3), .ZERO_R0(0)) dut_a (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_port_1(write_data), .read_en_1(read_en_1), .read_en_2(read_en_2),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .read_port_1(rp1_a), .read_port_2(rp2_a),
    .read_valid_1(rv1_a), .read_valid_2(rv2_a), .addr_err(err_a)
  );

  register_file_2r1w #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_R0(1)) dut_b (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_port_1(write_data), .read_en_1(read_en_1), .read_en_2(read_en_2),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .read_port_1(rp1_b), .read_port_2(rp2_b),
    .read_valid_1(rv1_b), .read_valid_2(rv2_b), .addr_err(err_b)
  );

  // ---------------- reference model ----------------
  int          dep [2] = '{6, 8};
  bit          zr  [2] = '{1'b0, 1'b1};
  logic [15:0] m   [2][8];
  logic [15:0] exp_port  [2][2];
  bit          exp_valid [2][2];
  bit          exp_err   [2];

  task automatic model_edge();
    bit          ren [2];
    int          radr [2];
    int          wadr;
    ren[0] = read_en_1;        ren[1] = read_en_2;
    radr[0] = int'(read_addr_1); radr[1] = int'(read_addr_2);
    wadr = int'(write_addr);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int e = 0; e < 8; e++) m[d][e] = 16'h0;
        for (int p = 0; p < 2; p++) begin
          exp_port[d][p]  = 16'h0;
          exp_valid[d][p] = 1'b0;
        end
        exp_err[d] = 1'b0;
      end else begin
        // Write lands first, so a same-edge read sees the new value.
        if (write_en) begin
          if (wadr >= dep[d]) exp_err[d] = 1'b1;
          else if (!(zr[d] && wadr == 0)) m[d][wadr] = write_data;
        end
        for (int p = 0; p < 2; p++) begin
          exp_valid[d][p] = ren[p];
          if (ren[p]) begin
            if (radr[p] >= dep[d]) begin
              exp_port[d][p] = 16'h0;
              exp_err[d] = 1'b1;
            end else if (zr[d] && radr[p] == 0) begin
              exp_port[d][p] = 16'h0;
            end else begin
              exp_port[d][p] = m[d][radr[p]];
            end
          end
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("A.port1",  {16'h0, rp1_a}, {16'h0, exp_port[0][0]});
    check("A.port2",  {16'h0, rp2_a}, {16'h0, exp_port[0][1]});
    check("A.valid1", {31'h0, rv1_a}, {31'h0, exp_valid[0][0]});
    check("A.valid2", {31'h0, rv2_a}, {31'h0, exp_valid[0][1]});
    check("A.err",    {31'h0, err_a}, {31'h0, exp_err[0]});
    check("B.port1",  {16'h0, rp1_b}, {16'h0, exp_port[1][0]});
    check("B.port2",  {16'h0, rp2_b}, {16'h0, exp_port[1][1]});
    check("B.valid1", {31'h0, rv1_b}, {31'h0, exp_valid[1][0]});
    check("B.valid2", {31'h0, rv2_b}, {31'h0, exp_valid[1][1]});
    check("B.err",    {31'h0, err_b}, {31'h0, exp_err[1]});
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    $display("[TB] t=%0t rst=%0b we=%0b wa=%0d wd=%h re=%0b%0b ra=%0d/%0d | A %h/%h v%0b%0b e%0b | B %h/%h v%0b%0b e%0b",
             $time, reset, write_en, write_addr, write_data, read_en_1, read_en_2,
             read_addr_1, read_addr_2, rp1_a, rp2_a, rv1_a, rv2_a, err_a,
             rp1_b, rp2_b, rv1_b, rv2_b, err_b);
  endtask

  task automatic idle();
    reset = 1'b0; write_en = 1'b0; write_addr = 3'd0; write_data = 16'h0;
    read_en_1 = 1'b0; read_en_2 = 1'b0; read_addr_1 = 3'd0; read_addr_2 = 3'd0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    write_en = 1'b1; write_addr = a; write_data = d;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    idle();
    // reset state is covered by the model comparisons of the cycles above

    // Read of a never-written entry after reset.
    read_en_1 = 1'b1; read_addr_1 = 3'd5;
    cycle();
    check("req028.port", {16'h0, rp1_a}, 32'h0);
    check("req028.valid", {31'h0, rv1_a}, 32'h1);
    idle();

    // Write then read on both ports.
    do_write(3'd3, 16'hBEEF);
    cycle();
    idle();
    read_en_1 = 1'b1; read_addr_1 = 3'd3;
    read_en_2 = 1'b1; read_addr_2 = 3'd3;
    cycle();
    check("req029.port1", {16'h0, rp1_a}, 32'hBEEF);
    check("req029.port2", {16'h0, rp2_a}, 32'hBEEF);
    check("req029.valid", {30'h0, rv1_a, rv2_a}, 32'h3);
    idle();
    cycle();
    check("valid_drops", {30'h0, rv1_a, rv2_a}, 32'h0);
    check("port_holds", {16'h0, rp1_a}, 32'hBEEF);

    // Same-edge write/read bypass.
    do_write(3'd2, 16'hBEEF);
    cycle();
    do_write(3'd2, 16'h1234);
    read_en_1 = 1'b1; read_addr_1 = 3'd2;
    cycle();
    check("req030.bypass", {16'h0, rp1_a}, 32'h1234);
    idle();

    // Out-of-range write and read on the DEPTH=6 instance.
    do_write(3'd7, 16'h5555);
    cycle();
    check("req031.err_wr", {31'h0, err_a}, 32'h1);
    idle();
    read_en_1 = 1'b1; read_addr_1 = 3'd7;
    cycle();
    check("req031.port", {16'h0, rp1_a}, 32'h0);
    check("req031.valid", {31'h0, rv1_a}, 32'h1);
    idle();
    for (int a = 0; a < 6; a++) begin
      read_en_1 = 1'b1; read_addr_1 = 3'(a);
      read_en_2 = 1'b1; read_addr_2 = 3'(5 - a);
      cycle();
    end
    idle();
    check("req031.sticky", {31'h0, err_a}, 32'h1);

    // Hard-wired zero entry on the ZERO_R0 instance.
    do_write(3'd0, 16'hFFFF);
    read_en_1 = 1'b1; read_addr_1 = 3'd0;
    cycle();
    check("req032.bypass", {16'h0, rp1_b}, 32'h0);
    idle();
    read_en_1 = 1'b1; read_addr_1 = 3'd0;
    cycle();
    check("req032.later", {16'h0, rp1_b}, 32'h0);
    idle();

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      write_en    = ($urandom_range(0, 1) == 1);
      write_addr  = 3'($urandom_range(0, 7));
      write_data  = 16'($urandom);
      read_en_1   = ($urandom_range(0, 9) < 7);
      read_en_2   = ($urandom_range(0, 9) < 7);
      // Bias toward the write address to exercise forwarding.
      read_addr_1 = ($urandom_range(0, 3) == 0) ? write_addr : 3'($urandom_range(0, 7));
      read_addr_2 = ($urandom_range(0, 3) == 0) ? write_addr : 3'($urandom_range(0, 7));
      cycle();
    end
    idle();

    // Make sure the error flag is set, then reset wins over a same-edge write.
    do_write(3'd7, 16'h0001);
    cycle();
    reset = 1'b1;
    do_write(3'd1, 16'hAAAA);
    cycle();
    idle();
    read_en_1 = 1'b1; read_addr_1 = 3'd1;
    cycle();
    check("req033.port", {16'h0, rp1_a}, 32'h0);
    check("req033.err", {31'h0, err_a}, 32'h0);
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/register_file_2r1w.md
REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per entry (1..64).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (2..256, need not be a power of two).
REQ-003 SHALL have parameter AW, default 3, address bits, with 2^AW >= DEPTH.
REQ-004 SHALL have parameter ZERO_R0, default 0; when set to 1, entry 0 is hard-wired to zero.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port write_en, input, 1 bit: write request.
REQ-008 SHALL have port write_addr, input, AW bits: write address.
REQ-009 SHALL have port write_port_1, input, WIDTH bits: write data.
REQ-010 SHALL have ports read_en_1 and read_en_2, input, 1 bit each: read request per port.
REQ-011 SHALL have ports read_addr_1 and read_addr_2, input, AW bits each: read address per port.
REQ-012 SHALL have ports read_port_1 and read_port_2, output, WIDTH bits each: registered read data.
REQ-013 SHALL have ports read_valid_1 and read_valid_2, output, 1 bit each: read data valid, one-cycle pulse.
REQ-014 SHALL have port addr_err, output, 1 bit: sticky out-of-range access flag.

Function
REQ-015 SHALL write write_port_1 into entry write_addr at a clock edge where write_en=1, write_addr<DEPTH, and the entry is not entry 0 under ZERO_R0=1.
REQ-016 SHALL have read latency of exactly 1 cycle: read_en_x=1 at edge N updates read_port_x and sets read_valid_x=1 after edge N.
REQ-017 SHALL drive read_valid_x=0 after any edge where read_en_x=0, while read_port_x holds its last value (no X, no clear).
REQ-018 SHALL make each read port fully independent; both ports may read the same or different addresses in the same cycle.
REQ-019 SHALL bypass write-first: when write_en=1, the write is valid, and read_addr_x==write_addr at the same edge, read_port_x returns write_port_1, not the old contents.
REQ-020 SHALL return 0 for any read of entry 0 under ZERO_R0=1, including the bypass case.
REQ-021 SHALL treat a read with read_addr_x>=DEPTH as follows: read_port_x<=0, read_valid_x<=1, addr_err<=1.
REQ-022 SHALL ignore a write with write_addr>=DEPTH (no entry changes) and set addr_err<=1.
REQ-023 SHALL keep addr_err sticky until reset; it SHALL be the only way to clear the flag.
REQ-024 SHALL update only on the clock edge; no output may depend combinationally on any input.

Reset
REQ-025 SHALL, at an edge where reset=1, clear all entries, read_port_1, read_port_2, read_valid_1, read_valid_2 and addr_err to 0.
REQ-026 SHALL give reset priority over every same-edge write and read; those requests are discarded.
REQ-027 SHALL accept operations on the first edge after reset deasserts, with no warm-up cycles.

Verification
REQ-028 SHALL be checked by this directed test: after reset, read_en_1=1 with read_addr_1=5 -> one cycle later read_port_1=0 and read_valid_1=1.
REQ-029 SHALL be checked by this directed test: write 16'hBEEF to address 3, then next cycle read address 3 on both ports -> both read_port_x=16'hBEEF and both read_valid_x=1 exactly one cycle later.
REQ-030 SHALL be checked by this directed test: in the same cycle, write 16'h1234 to address 2 and read_addr_1=2 (old value 16'hBEEF) -> read_port_1=16'h1234.
REQ-031 SHALL be checked by this directed test: with DEPTH=6, write to address 7 then read address 7 -> no entry changes, read_port_1=0, and addr_err=1 stays set until reset.
REQ-032 SHALL be checked by this directed test: with ZERO_R0=1, write 16'hFFFF to address 0 with a same-cycle read of address 0 -> read_port_1=0 in that read and in every later read.
REQ-033 SHALL be checked by this directed test: assert reset in the same cycle as a write of 16'hAAAA to address 1 -> the following read of address 1 returns 0 and addr_err=0.
